// File: rtl/led_serial2parallel.sv
// Board-side receiver for the led_clk/led_pen/led_dat shift protocol; rebuilds the parallel LED word.
// Pins are synchronised into clk; data_valid lands on the 3rd clk edge after led_pen rises.
module led_serial2parallel #(
  parameter int WIDTH   = 16,
  parameter bit INVERT  = 1'b0,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             led_clk,
  input  logic             led_pen,
  input  logic             led_dat,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // [0],[1] form the synchroniser, [2] is the history flop for edge detection
  logic [2:0] clk_sh_q;
  logic [2:0] pen_sh_q;
  logic [1:0] dat_sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sh_q <= '0;
      pen_sh_q <= '0;
      dat_sh_q <= '0;
    end else begin
      clk_sh_q <= {clk_sh_q[1:0], led_clk};
      pen_sh_q <= {pen_sh_q[1:0], led_pen};
      dat_sh_q <= {dat_sh_q[0], led_dat};
    end
  end

  logic clk_rise, pen_rise, pen_sync, dat_sync;
  assign clk_rise = clk_sh_q[1] & ~clk_sh_q[2];
  assign pen_rise = pen_sh_q[1] & ~pen_sh_q[2];
  assign pen_sync = pen_sh_q[1];
  assign dat_sync = dat_sh_q[1];

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [TW-1:0]    to_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             frame_err_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clk_rise && !pen_sync) begin
            sr_q    <= {{(WIDTH-1){1'b0}}, dat_sync};
            cnt_q   <= CW'(1);
            to_q    <= '0;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          // Pen rise outranks a coincident clock rise, so that edge is never shifted in
          if (pen_rise) begin
            if (cnt_q == CW'(WIDTH)) begin
              data_out_q   <= INVERT ? ~sr_q : sr_q;
              data_valid_q <= 1'b1;
            end else begin
              frame_err_q  <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (clk_rise && !pen_sync) begin
            sr_q <= {sr_q[WIDTH-2:0], dat_sync};
            if (cnt_q != CW'(WIDTH + 1)) cnt_q <= cnt_q + CW'(1);
            to_q <= '0;
          end else if (to_q == TW'(TIMEOUT - 1)) begin
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
